// File: rtl/exp_golomb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exp_golomb_pkg
// Description : Shared definitions for the order-0 Exp-Golomb decoder:
//               decoder state type, default widths and the codeword-length
//               helper, which the testbench also uses.
// Revision    : 1.0 - initial release
// ============================================================================
package exp_golomb_pkg;

    // PREFIX with a zero count of 0 is the idle condition; no separate state.
    typedef enum logic [0:0] {
        PREFIX = 1'b0,
        SUFFIX = 1'b1
    } eg_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    // Number of bits in a codeword with n leading zeros.
    function automatic int code_len(input int n);
        return 2 * n + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exp_golomb_decoder.sv
`default_nettype none
// ============================================================================
// Module      : exp_golomb_decoder
// Description : Serial-to-parallel order-0 Exp-Golomb decoder. Takes one code
//               bit per valid cycle (MSB first), counts N leading zeros, the
//               marker 1 and N suffix bits, and emits x = {1,suffix} - 1.
// Ports       : clk_i    - clock, rising edge
//               rstn_i   - asynchronous active-low reset
//               dft_tm_i - test mode, forces internal reset inactive
//               dt_i     - serial code bit, sampled when valid_i = 1
//               valid_i  - dt_i qualifier, may gap anywhere in a codeword
//               dt_o     - decoded value, held until next completion
//               valid_o  - one-cycle pulse, dt_o updated
//               err_o    - one-cycle pulse, prefix too long or overflow
//               busy_o   - codeword in progress
// Revision    : 1.0 - initial release
// ============================================================================
module exp_golomb_decoder
    import exp_golomb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  dft_tm_i,
    input  logic                  dt_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] dt_o,
    output logic                  valid_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam logic [ADDR_WIDTH-1:0] ZMAX     = ADDR_WIDTH'(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ZERO_CNT = '0;
    localparam logic [ADDR_WIDTH-1:0] ONE_CNT  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH:0]   ACC_INIT = (DATA_WIDTH+1)'(1);

    // Test mode holds the internal reset released so scan shifting is not
    // disturbed by the functional reset pin.
    logic rstn_b;
    assign rstn_b = dft_tm_i | rstn_i;

    eg_state_t             state, state_n;
    logic [ADDR_WIDTH-1:0] zcnt, zcnt_n;
    logic [ADDR_WIDTH-1:0] rem, rem_n;
    logic [DATA_WIDTH:0]   acc, acc_n;
    logic [DATA_WIDTH-1:0] dt_n;
    logic                  valid_n;
    logic                  err_n;

    // Full codeword {1,suffix} including the bit arriving now, one bit wider
    // than the accumulator so no significance is lost before the subtract.
    logic [DATA_WIDTH+1:0] final_word;
    logic [DATA_WIDTH+1:0] result;
    logic                  overflow;

    assign final_word = {acc, dt_i};
    assign result     = final_word - (DATA_WIDTH+2)'(1);
    assign overflow   = |result[DATA_WIDTH+1:DATA_WIDTH];

    always_ff @(posedge clk_i or negedge rstn_b) begin
        if (!rstn_b) begin
            state   <= PREFIX;
            zcnt    <= ZERO_CNT;
            rem     <= ZERO_CNT;
            acc     <= ACC_INIT;
            dt_o    <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state   <= state_n;
            zcnt    <= zcnt_n;
            rem     <= rem_n;
            acc     <= acc_n;
            dt_o    <= dt_n;
            valid_o <= valid_n;
            err_o   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        zcnt_n  = zcnt;
        rem_n   = rem;
        acc_n   = acc;
        dt_n    = dt_o;
        valid_n = 1'b0;
        err_n   = 1'b0;

        if (valid_i) begin
            case (state)
                PREFIX: begin
                    if (!dt_i) begin
                        if (zcnt == ZMAX) begin
                            // Prefix longer than any legal code: flag it and
                            // let the next bits start a fresh codeword.
                            err_n  = 1'b1;
                            zcnt_n = ZERO_CNT;
                        end else begin
                            zcnt_n = zcnt + ONE_CNT;
                        end
                    end else if (zcnt == ZERO_CNT) begin
                        // Single-bit codeword "1" encodes zero.
                        dt_n    = '0;
                        valid_n = 1'b1;
                    end else begin
                        acc_n   = ACC_INIT;
                        rem_n   = zcnt;
                        zcnt_n  = ZERO_CNT;
                        state_n = SUFFIX;
                    end
                end
                SUFFIX: begin
                    acc_n = {acc[DATA_WIDTH-1:0], dt_i};
                    rem_n = rem - ONE_CNT;
                    if (rem == ONE_CNT) begin
                        state_n = PREFIX;
                        if (overflow) begin
                            err_n = 1'b1;
                        end else begin
                            dt_n    = result[DATA_WIDTH-1:0];
                            valid_n = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = PREFIX;
                end
            endcase
        end
    end

    assign busy_o = (state == SUFFIX) || (zcnt != ZERO_CNT);

endmodule
`default_nettype wire

// File: tb/tb_exp_golomb_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_golomb_decoder
// Description : Self-checking bench for exp_golomb_decoder. A bit-queue
//               parser predicts every output each cycle; directed sequences
//               add literal expectations, then randomized codewords, gaps,
//               errors and resets exercise the rest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_golomb_decoder;
    import exp_golomb_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;
    localparam int AW = DEFAULT_ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          dft_tm_i;
    logic          dt_i;
    logic          valid_i;
    logic [DW-1:0] dt_o;
    logic          valid_o;
    logic          err_o;
    logic          busy_o;

    exp_golomb_decoder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i   (clk),
        .rstn_i  (rstn_i),
        .dft_tm_i(dft_tm_i),
        .dt_i    (dt_i),
        .valid_i (valid_i),
        .dt_o    (dt_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // ---------------- reference model ----------------
    // Accepted bits of the codeword in progress; parsed from scratch after
    // every accepted bit.
    bit      q[$];
    bit      cw[$];
    int      exp_dt    = 0;
    bit      exp_valid = 0;
    bit      exp_err   = 0;
    bit      exp_busy  = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_compared++;
        if (act != expv) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit in_reset();
        return !(dft_tm_i || rstn_i);
    endfunction

    task automatic model_clear();
        q.delete();
        exp_dt    = 0;
        exp_valid = 0;
        exp_err   = 0;
        exp_busy  = 0;
    endtask

    task automatic model_parse();
        int z;
        int val;
        z = 0;
        while (z < q.size() && q[z] == 1'b0) z++;
        if (z == q.size()) begin
            if (z > DW) begin
                exp_err = 1;
                q.delete();
            end
        end else if (q.size() == code_len(z)) begin
            val = 0;
            for (int i = z; i < q.size(); i++) val = val * 2 + int'(q[i]);
            val = val - 1;
            if (val >= (1 << DW)) exp_err = 1;
            else begin
                exp_valid = 1;
                exp_dt    = val;
            end
            q.delete();
        end
    endtask

    task automatic model_step(input bit v, input bit b);
        exp_valid = 0;
        exp_err   = 0;
        if (in_reset()) begin
            model_clear();
        end else if (v) begin
            q.push_back(b);
            model_parse();
        end
        exp_busy = (q.size() != 0);
    endtask

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("valid_o", int'(valid_o), int'(exp_valid));
        chk("err_o",   int'(err_o),   int'(exp_err));
        chk("dt_o",    int'(dt_o),    exp_dt);
        chk("busy_o",  int'(busy_o),  int'(exp_busy));
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 1 time unit after a rising edge; the model then advances
    // with what the DUT sampled at the following edge.
    task automatic send_bit(input bit b, input bit v);
        dt_i    = b;
        valid_i = v;
        @(posedge clk);
        #1;
        model_step(v, b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_bit(s[i] == 8'h31, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        rstn_i = 1'b0;
        #1;
        if (in_reset()) begin
            model_clear();
            chk("rst_busy",  int'(busy_o),  0);
            chk("rst_valid", int'(valid_o), 0);
            chk("rst_dt",    int'(dt_o),    0);
        end
        for (int i = 0; i < cycles; i++) send_bit(1'b0, 1'b0);
        rstn_i = 1'b1;
    endtask

    // Code for value x: n zeros, then the n+1 bits of x+1.
    task automatic build(input int n, input int word);
        cw.delete();
        for (int i = 0; i < n; i++) cw.push_back(1'b0);
        for (int i = n; i >= 0; i--) cw.push_back(word[i]);
    endtask

    task automatic emit(input int limit);
        for (int i = 0; i < limit; i++) begin
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) send_bit(1'($urandom_range(0, 1)), 1'b0);
            send_bit(cw[i], 1'b1);
        end
    endtask

    initial begin
        int v;
        int n;
        int kind;
        rstn_i   = 1'b0;
        dft_tm_i = 1'b0;
        dt_i     = 1'b0;
        valid_i  = 1'b0;
        repeat (3) send_bit(1'b0, 1'b0);
        rstn_i = 1'b1;
        send_bit(1'b0, 1'b0);
        chk("reset_dt",   int'(dt_o),   0);
        chk("reset_busy", int'(busy_o), 0);

        // "1" -> 0
        send_str("1");
        chk("c1_valid", int'(valid_o), 1);
        chk("c1_dt",    int'(dt_o),    0);
        chk("c1_busy",  int'(busy_o),  0);
        send_bit(1'b0, 1'b0);

        // "00110" -> 5
        send_str("0");
        chk("c5_busy_first", int'(busy_o), 1);
        send_str("0110");
        chk("c5_valid", int'(valid_o), 1);
        chk("c5_dt",    int'(dt_o),    5);
        chk("model_c5", exp_dt,        5);
        send_bit(1'b0, 1'b0);

        // 255 with a 3-cycle gap mid-suffix
        send_str("000000001");
        send_str("0000");
        repeat (3) send_bit(1'b1, 1'b0);
        chk("c255_busy_gap", int'(busy_o), 1);
        send_str("0000");
        chk("c255_valid", int'(valid_o), 1);
        chk("c255_err",   int'(err_o),   0);
        chk("c255_dt",    int'(dt_o),    255);
        chk("model_c255", exp_dt,        255);

        // back-to-back 0,1,2,3
        send_str("1");
        chk("b2b_0", int'(dt_o), 0);
        send_str("010");
        chk("b2b_1", int'(dt_o), 1);
        send_str("011");
        chk("b2b_2", int'(dt_o), 2);
        send_str("00100");
        chk("b2b_3", int'(dt_o), 3);
        chk("b2b_3v", int'(valid_o), 1);

        // nine zeros -> prefix error, dt_o held
        send_str("000000000");
        chk("perr_err",   int'(err_o),   1);
        chk("perr_valid", int'(valid_o), 0);
        chk("perr_dt",    int'(dt_o),    3);
        send_str("1");
        chk("perr_next",  int'(dt_o),    0);

        // 8 zeros + "100000001" -> value 256 overflows
        send_str("011");
        send_str("00000000100000001");
        chk("ovf_err",   int'(err_o),   1);
        chk("ovf_valid", int'(valid_o), 0);
        chk("ovf_dt",    int'(dt_o),    2);
        chk("model_ovf", int'(exp_err), 1);

        // reset during the suffix of "00110"
        send_str("0011");
        chk("pre_rst_busy", int'(busy_o), 1);
        do_reset(2);
        send_str("010");
        chk("post_rst_dt", int'(dt_o), 1);

        // test mode: reset pulse ignored mid-codeword
        dft_tm_i = 1'b1;
        send_str("0");
        rstn_i = 1'b0;
        #1;
        chk("dft_busy", int'(busy_o), 1);
        send_bit(1'b0, 1'b0);
        rstn_i = 1'b1;
        send_str("11");
        chk("dft_dt", int'(dt_o), 2);
        dft_tm_i = 1'b0;

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                cw.delete();
                for (int i = 0; i <= DW; i++) cw.push_back(1'b0);
                emit(cw.size());
            end else if (kind == 1) begin
                build(DW, (1 << DW) + $urandom_range(1, (1 << DW) - 1));
                emit(cw.size());
            end else if (kind == 2 || kind == 3) begin
                v = $urandom_range(1, 1 << DW);
                n = $clog2(v + 1) - 1;
                build(n, v);
                if (cw.size() > 1) emit($urandom_range(1, cw.size() - 1));
                if (kind == 3) dft_tm_i = 1'b1;
                do_reset($urandom_range(1, 2));
                dft_tm_i = 1'b0;
            end else begin
                v = (kind < 10) ? $urandom_range(1, 8) : $urandom_range(1, 1 << DW);
                n = $clog2(v + 1) - 1;
                build(n, v);
                emit(cw.size());
            end
        end
        repeat (3) send_bit(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exp_golomb_decoder.md
Name: exp_golomb_decoder

Overview:
- Serial-to-parallel order-0 Exp-Golomb decoder; the receive end of the exp_golomb_coder bitstream.
- Accepts one code bit per valid cycle, MSB first.
- Counts the N leading zeros, then the marker 1, then N suffix bits.
- Emits the decoded value x = {1, suffix} - 1 as a DATA_WIDTH word with a one-cycle valid pulse. Tolerates gaps in valid_i and back-to-back codewords.

Parameters:
DATA_WIDTH, 8, width of decoded value; max legal prefix length N = DATA_WIDTH
ADDR_WIDTH, 4, width of zero/suffix counters; must satisfy 2^ADDR_WIDTH > DATA_WIDTH

Ports:
clk_i  input  1  clock, all state on rising edge
rstn_i  input  1  asynchronous active-low reset
dft_tm_i  input  1  test mode; when 1, internal reset is forced inactive (rstn_b = dft_tm_i ? 1 : rstn_i)
dt_i  input  1  serial code bit, sampled only when valid_i=1
valid_i  input  1  dt_i qualifier; may deassert anywhere inside a codeword
dt_o  output  DATA_WIDTH  decoded value, registered, held until next completion
valid_o  output  1  one-cycle pulse: dt_o updated this cycle
err_o  output  1  one-cycle pulse: prefix too long or value overflow
busy_o  output  1  codeword in progress (prefix count != 0 or state SUFFIX)

Behaviour:
- Interface: one clock, clk_i; reset rstn_i is asynchronous and active-low, gated by dft_tm_i as above.
- Reset values: dt_o=0, valid_o=0, err_o=0, busy_o=0, state PREFIX, zcnt=0, rem=0, acc=1 (width DATA_WIDTH+1).
- States (in shared package): PREFIX, SUFFIX. No explicit idle: PREFIX with zcnt=0 is idle.
- Only cycles with valid_i=1 advance state. valid_i=0 holds every register; valid_o and err_o return to 0.
- PREFIX, bit 0:
  - zcnt<DATA_WIDTH: zcnt++.
  - zcnt==DATA_WIDTH: err_o=1 next cycle, zcnt<=0, stay in PREFIX (resync; following bits restart a codeword).
- PREFIX, bit 1:
  - zcnt==0: codeword "1" complete; dt_o<=0, valid_o=1 next cycle.
  - zcnt>0: acc<=1, rem<=zcnt, zcnt<=0, go to SUFFIX.
- SUFFIX, each valid bit: acc<={acc[DATA_WIDTH-1:0],dt_i}, rem--.
  - On the bit where rem==1: codeword complete, go to PREFIX.
  - Result r = {acc,dt_i} - 1, computed at DATA_WIDTH+1 bits.
  - If r >= 2^DATA_WIDTH: err_o=1, dt_o unchanged, valid_o=0.
  - Otherwise dt_o<=r[DATA_WIDTH-1:0], valid_o=1.
- Latency: valid_o/err_o asserted in the cycle after the final code bit is accepted. Total 2N+1 accepted bits + 1 cycle.
- Back-to-back: the first bit of the next codeword may be presented in the same cycle valid_o pulses; no bubble is required.
- valid_o and err_o are never both 1.
- busy_o is combinational from registers: (state==SUFFIX) || (zcnt!=0).
- Reset mid-codeword discards the partial code; no valid_o or err_o is produced for it.

Decomposition:
- Package exp_golomb_pkg:
  - state typedef (PREFIX, SUFFIX).
  - default DATA_WIDTH/ADDR_WIDTH constants.
  - function code_len(N)=2N+1, shared with the bench.
- Single module; no sub-module is natural. Counters, accumulator and the output register are under ~200 lines.

Test Plan:
- Bits "1" -> valid_o pulse, dt_o=0, busy_o stays 0.
- Bits "00110" contiguous -> valid_o one cycle after 5th bit, dt_o=5; busy_o high from 1st bit through 5th.
- 8 zeros, then 1, then 8 zeros (code for 255), with valid_i dropped for 3 cycles mid-suffix -> dt_o=255, single valid_o pulse, no err_o.
- Back-to-back "1","010","011","00100" with valid_i always 1 -> dt_o sequence 0,1,2,3, each valid_o one cycle after its last bit.
- Two error cases:
  - 9 zeros -> err_o pulse after 9th zero, dt_o unchanged; following "1" decodes to 0.
  - 8 zeros + "100000001" -> err_o (value 256 overflows), no valid_o.
- Assert rstn_i low during SUFFIX of "00110" -> outputs/busy_o 0 immediately. After release, "010" -> dt_o=1. With dft_tm_i=1, rstn_i pulse has no effect.
